// File: rtl/jtframe_joyser_if.sv
// rtl/jtframe_joyser_if.sv - pin bundle between the joystick reader and the serial pad chain
//
// Purpose: groups the four wires of a parallel-in/serial-out joystick chain.
// Signals:
//   JOY_DATA    serial data from the chain (asynchronous to the reader clock)
//   JOY_CLK     shift clock to the chain; the chain advances on its falling edge
//   JOY_LOAD    parallel load, active low
//   JOY_SELECT  pad select line (1 = phase A, 0 = phase B on 6-button pads)
// Modports:
//   master      the reader (jtframe_joyser)
//   slave       the chain / pad model
interface jtframe_joyser_if;
  logic JOY_DATA;
  logic JOY_CLK;
  logic JOY_LOAD;
  logic JOY_SELECT;

  modport master (
    input  JOY_DATA,
    output JOY_CLK,
    output JOY_LOAD,
    output JOY_SELECT
  );

  modport slave (
    output JOY_DATA,
    input  JOY_CLK,
    input  JOY_LOAD,
    input  JOY_SELECT
  );
endinterface

// File: rtl/jtframe_joyser.sv
// rtl/jtframe_joyser.sv - serial joystick chain reader with atomic per-player output words
//
// Purpose: periodically loads and shifts a parallel-in/serial-out joystick
// chain, optionally in two select phases for 6-button pads, and publishes
// one active-low word per joystick only once a whole frame has been read.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset (released synchronously upstream)
//   en       1: run frames back to back; 0: halt after the current frame
//   pad      chain pins (master side of jtframe_joyser_if)
//   joy      active-low buttons, joystick j at [JW*j +: JW]
//   joy_stb  one-cycle pulse in the cycle joy takes a new value
//   busy     high while a frame is in progress
module jtframe_joyser #(
  parameter int NJOY   = 2,
  parameter int MODE6  = 0,
  parameter int CLKDIV = 8,
  parameter int SETTLE = 64,
  parameter int IDLE   = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  jtframe_joyser_if.master            pad,
  output logic [NJOY*8*(1+MODE6)-1:0] joy,
  output logic                        joy_stb,
  output logic                        busy
);
  localparam int JW   = 8*(1+MODE6);
  localparam int NB   = 8*NJOY;
  localparam int PER  = 2*CLKDIV;
  localparam int TMAX = (SETTLE > PER) ? SETTLE : PER;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = $clog2(NB);
  localparam int IW   = (IDLE > 1) ? $clog2(IDLE) : 1;

  localparam logic [TW-1:0] SETTLE_END = TW'(SETTLE-1);
  localparam logic [TW-1:0] PER_END    = TW'(PER-1);
  localparam logic [TW-1:0] HALF       = TW'(CLKDIV);
  localparam logic [BW-1:0] BIT_END    = BW'(NB-1);
  localparam logic [IW-1:0] IDLE_END   = IW'(IDLE-1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEL   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]         r_state;
  logic [TW-1:0]      r_tmr;
  logic [BW-1:0]      r_bit;
  logic [IW-1:0]      r_idle;
  logic               r_phase;   // 0 = phase A (select high), 1 = phase B
  logic               r_sync1;
  logic               r_sync2;
  logic [NB-1:0]      r_sbuf;
  logic [NB-1:0]      r_sbuf_a;
  logic [NJOY*JW-1:0] r_joy;
  logic               r_stb;
  logic               r_busy;
  logic               r_clk;
  logic               r_load;
  logic               r_sel;

  logic [2:0]         w_state_n;
  logic [TW-1:0]      w_tmr_n;
  logic [BW-1:0]      w_bit_n;
  logic [IW-1:0]      w_idle_n;
  logic               w_phase_n;
  logic               w_sample;
  logic [NJOY*JW-1:0] w_joy_n;

  // The data bit sits stable on the chain for a whole JOY_CLK period, so it
  // is taken on the last cycle of the high half, just before the falling
  // edge that advances the chain.
  assign w_sample = (r_state == ST_SHIFT) && (r_tmr == PER_END);

  always_comb begin
    w_state_n = r_state;
    w_tmr_n   = r_tmr;
    w_bit_n   = r_bit;
    w_idle_n  = r_idle;
    w_phase_n = r_phase;
    case (r_state)
      ST_IDLE: begin
        // Counter saturates at terminal count so a held-off frame starts
        // in the very cycle en comes back.
        if (r_idle == IDLE_END) begin
          if (en) begin
            w_state_n = ST_SEL;
            w_tmr_n   = '0;
            w_phase_n = 1'b0;
          end
        end else begin
          w_idle_n = r_idle + 1'b1;
        end
      end
      ST_SEL: begin
        if (r_tmr == SETTLE_END) begin
          w_state_n = ST_LOAD;
          w_tmr_n   = '0;
        end else begin
          w_tmr_n = r_tmr + 1'b1;
        end
      end
      ST_LOAD: begin
        if (r_tmr == PER_END) begin
          w_state_n = ST_SHIFT;
          w_tmr_n   = '0;
          w_bit_n   = '0;
        end else begin
          w_tmr_n = r_tmr + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_tmr == PER_END) begin
          w_tmr_n = '0;
          if (r_bit == BIT_END) begin
            w_state_n = ST_NEXT;
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end else begin
          w_tmr_n = r_tmr + 1'b1;
        end
      end
      ST_NEXT: begin
        if ((MODE6 != 0) && !r_phase) begin
          w_state_n = ST_SEL;
          w_phase_n = 1'b1;
          w_tmr_n   = '0;
        end else begin
          w_state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
        w_idle_n  = '0;
      end
      default: begin
        w_state_n = ST_IDLE;
        w_idle_n  = '0;
      end
    endcase
  end

  // Output word assembly: byte 0 of every joystick comes from phase A, the
  // optional upper byte from phase B. Without MODE6 the only scan is phase A
  // and it is still sitting in r_sbuf.
  always_comb begin
    w_joy_n = '1;
    for (int j = 0; j < NJOY; j++) begin
      for (int b = 0; b < JW/8; b++) begin
        w_joy_n[JW*j+8*b +: 8] = ((MODE6 != 0) && (b == 0)) ? r_sbuf_a[8*j +: 8]
                                                            : r_sbuf[8*j +: 8];
      end
    end
  end

  // Pin and status outputs are registered from the next-state values so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_tmr    <= '0;
      r_bit    <= '0;
      r_idle   <= '0;
      r_phase  <= 1'b0;
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sbuf   <= '1;
      r_sbuf_a <= '1;
      r_joy    <= '1;
      r_stb    <= 1'b0;
      r_busy   <= 1'b0;
      r_clk    <= 1'b0;
      r_load   <= 1'b1;
      r_sel    <= 1'b1;
    end else begin
      r_sync1 <= pad.JOY_DATA;
      r_sync2 <= r_sync1;

      r_state <= w_state_n;
      r_tmr   <= w_tmr_n;
      r_bit   <= w_bit_n;
      r_idle  <= w_idle_n;
      r_phase <= w_phase_n;

      if (w_sample) begin
        r_sbuf[r_bit] <= r_sync2;
      end
      if ((r_state == ST_NEXT) && !r_phase) begin
        r_sbuf_a <= r_sbuf;
      end
      if (w_state_n == ST_DONE) begin
        r_joy <= w_joy_n;
      end

      r_stb  <= (w_state_n == ST_DONE);
      r_busy <= (w_state_n != ST_IDLE);
      r_clk  <= (w_state_n == ST_SHIFT) && (w_tmr_n >= HALF);
      r_load <= (w_state_n != ST_LOAD);
      // Select is driven low only while phase B is settling, loading or
      // shifting; it is already back high for NEXT and DONE.
      r_sel  <= !(w_phase_n && ((w_state_n == ST_SEL) ||
                                (w_state_n == ST_LOAD) ||
                                (w_state_n == ST_SHIFT)));
    end
  end

  assign pad.JOY_CLK    = r_clk;
  assign pad.JOY_LOAD   = r_load;
  assign pad.JOY_SELECT = r_sel;
  assign joy            = r_joy;
  assign joy_stb        = r_stb;
  assign busy           = r_busy;
endmodule

// File: tb/tb_jtframe_joyser.sv
// tb/tb_jtframe_joyser.sv - self-checking bench for jtframe_joyser (single-scan and 6-button builds)
`timescale 1ns/1ps
module tb_jtframe_joyser;
  localparam int NJOY   = 2;
  localparam int CLKDIV = 4;
  localparam int SETTLE = 8;
  localparam int IDLE   = 16;
  localparam int NB     = 8*NJOY;
  localparam int PER    = 2*CLKDIV;
  localparam int SEG    = SETTLE + PER*(1+NB);   // one SEL+LOAD+SHIFT pass

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b0;

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] word_a [2];
  logic [15:0] word_b [2];
  int stb_cnt   [2];
  int fl_last   [2];
  int rise_last [2];
  int lead_last [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int M6 = g;
    localparam int JW = 8*(1+M6);
    localparam int FL = (M6 != 0) ? 2*SEG+3 : SEG+2;

    jtframe_joyser_if pad();
    logic [NJOY*JW-1:0] joy;
    logic               joy_stb;
    logic               busy;

    jtframe_joyser #(
      .NJOY(NJOY), .MODE6(M6), .CLKDIV(CLKDIV), .SETTLE(SETTLE), .IDLE(IDLE)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pad(pad),
      .joy(joy), .joy_stb(joy_stb), .busy(busy)
    );

    // Chain: snapshot on load, present bit idx, advance on JOY_CLK fall.
    // Outside a scan the line carries free-running asynchronous noise.
    logic [NB-1:0] sh = '1;
    int            idx = NB;
    logic          noise = 1'b0;
    logic          chain_bit;

    always @(negedge pad.JOY_LOAD) begin
      sh  = pad.JOY_SELECT ? word_a[g] : word_b[g];
      idx = 0;
    end
    always @(negedge pad.JOY_CLK) begin
      if (pad.JOY_LOAD === 1'b1) idx = idx + 1;
    end
    initial begin
      forever begin
        #($urandom_range(3, 17));
        noise = ~noise;
      end
    end
    assign chain_bit    = (idx < NB) ? sh[idx] : noise;
    assign pad.JOY_DATA = chain_bit;

    // Reference: position inside the frame counted in cycles (-1 = idle).
    int m_off  = -1;
    int m_idle = 0;
    logic [NJOY*JW-1:0] m_joy = '1;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_off  = -1;
        m_idle = 0;
        m_joy  = '1;
      end else begin
        if (m_off < 0) begin
          if (m_idle >= IDLE-1 && en) m_off = 0;
          else m_idle++;
        end else if (m_off == FL-1) begin
          m_off  = -1;
          m_idle = 0;
        end else begin
          m_off++;
        end
        if (m_off == FL-1) begin
          for (int j = 0; j < NJOY; j++) begin
            for (int b = 0; b < JW/8; b++) begin
              logic [15:0] w;
              w = (b == 0) ? word_a[g] : word_b[g];
              m_joy[JW*j+8*b +: 8] = w[8*j +: 8];
            end
          end
        end
      end
    end

    int   fcyc = 0, rises = 0, lead = 0;
    bit   seen_ld = 1'b0;
    logic prev_clk = 1'b0;

    always @(negedge clk) begin
      logic e_clk, e_load, e_sel, e_stb, e_busy;
      int   o;
      bit   ph_b;
      e_clk  = 1'b0;
      e_load = 1'b1;
      e_sel  = 1'b1;
      e_stb  = 1'b0;
      e_busy = (m_off >= 0);
      if (m_off >= 0) begin
        o    = m_off;
        ph_b = 1'b0;
        if (M6 != 0 && o > SEG) begin
          o    = o - SEG - 1;
          ph_b = 1'b1;
        end
        if (o < SEG) begin
          if (ph_b) e_sel = 1'b0;
          if (o >= SETTLE && o < SETTLE+PER) e_load = 1'b0;
          else if (o >= SETTLE+PER) e_clk = (((o-SETTLE-PER) % PER) >= CLKDIV);
        end
        e_stb = (m_off == FL-1);
      end
      chk($sformatf("d%0d.busy", g),   64'(busy),           64'(e_busy));
      chk($sformatf("d%0d.clk", g),    64'(pad.JOY_CLK),    64'(e_clk));
      chk($sformatf("d%0d.load", g),   64'(pad.JOY_LOAD),   64'(e_load));
      chk($sformatf("d%0d.select", g), 64'(pad.JOY_SELECT), 64'(e_sel));
      chk($sformatf("d%0d.stb", g),    64'(joy_stb),        64'(e_stb));
      chk($sformatf("d%0d.joy", g),    64'(joy),            64'(m_joy));

      if (!rst_n) begin
        fcyc = 0; rises = 0; lead = 0; seen_ld = 1'b0;
      end else begin
        if (busy) fcyc++;
        if (pad.JOY_CLK && !prev_clk) rises++;
        if (!pad.JOY_SELECT && pad.JOY_LOAD && !seen_ld) lead++;
        if (!pad.JOY_SELECT && !pad.JOY_LOAD) seen_ld = 1'b1;
        if (joy_stb) begin
          stb_cnt[g]++;
          fl_last[g]   = fcyc;
          rise_last[g] = rises;
          lead_last[g] = lead;
          fcyc = 0; rises = 0; lead = 0; seen_ld = 1'b0;
        end
      end
      prev_clk = pad.JOY_CLK;
      if (e_stb) begin
        word_a[g] = 16'($urandom);
        word_b[g] = 16'($urandom);
      end
    end
  end

  task automatic wait_frames(input int g, input int n, input string nm);
    int s;
    int t;
    s = stb_cnt[g];
    t = 0;
    while (stb_cnt[g] < s + n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 64'(stb_cnt[g] >= s + n), 64'd1);
  endtask

  task automatic wait_shift0(input string nm);
    int t;
    t = 0;
    while (gi[0].pad.JOY_CLK !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 64'(gi[0].pad.JOY_CLK), 64'd1);
  endtask

  initial begin
    int s0;
    for (int g = 0; g < 2; g++) begin
      stb_cnt[g] = 0; fl_last[g] = 0; rise_last[g] = 0; lead_last[g] = 0;
    end
    word_a[0] = 16'hC35A; word_b[0] = 16'hFFFF;
    word_a[1] = 16'h0FFF; word_b[1] = 16'hF0FE;
    en = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.joy0",    64'(gi[0].joy),            64'hFFFF);
    chk("rst.joy1",    64'(gi[1].joy),            64'hFFFF_FFFF);
    chk("rst.busy0",   64'(gi[0].busy),           64'd0);
    chk("rst.load0",   64'(gi[0].pad.JOY_LOAD),   64'd1);
    chk("rst.select1", 64'(gi[1].pad.JOY_SELECT), 64'd1);
    chk("rst.clk0",    64'(gi[0].pad.JOY_CLK),    64'd0);
    rst_n = 1'b1;

    wait_frames(0, 1, "t1.frame");
    chk("t1.joy",      64'(gi[0].joy),  64'hC35A);
    chk("t1.len",      64'(fl_last[0]), 64'd146);
    chk("t3.rises0",   64'(rise_last[0]), 64'd16);
    wait_frames(1, 1, "t2.frame");
    chk("t2.joy",      64'(gi[1].joy),  64'hF00F_FEFF);
    chk("t2.rises1",   64'(rise_last[1]), 64'd32);
    chk("t2.sel_lead", 64'(lead_last[1] >= SETTLE), 64'd1);

    wait_frames(1, 3, "rnd.frames");

    wait_shift0("t4.in_shift");
    en = 1'b0;
    s0 = stb_cnt[0];
    repeat (700) @(negedge clk);
    chk("t4.one_stb",  64'(stb_cnt[0] - s0), 64'd1);
    chk("t4.halt0",    64'(gi[0].busy), 64'd0);
    chk("t4.halt1",    64'(gi[1].busy), 64'd0);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("t4.restart0", 64'(gi[0].busy), 64'd1);
    chk("t4.restart1", 64'(gi[1].busy), 64'd1);

    wait_frames(0, 2, "pre5.frames");
    wait_shift0("t5.in_shift");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.clk0",  64'(gi[0].pad.JOY_CLK),  64'd0);
    chk("t5.load0", 64'(gi[0].pad.JOY_LOAD), 64'd1);
    chk("t5.busy0", 64'(gi[0].busy),         64'd0);
    chk("t5.joy0",  64'(gi[0].joy),          64'hFFFF);
    chk("t5.joy1",  64'(gi[1].joy),          64'hFFFF_FFFF);
    word_a[0] = 16'h3CA5; word_b[0] = 16'hFFFF;
    word_a[1] = 16'h1234; word_b[1] = 16'h5678;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_frames(0, 1, "t5.frame0");
    chk("t5.post_joy0", 64'(gi[0].joy), 64'h3CA5);
    wait_frames(1, 1, "t5.frame1");
    chk("t5.post_joy1", 64'(gi[1].joy), 64'h5612_7834);

    wait_frames(1, 4, "rnd.tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
